// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with relative branch and call/return stack
// Optional circular stack (overflow overwrites oldest entry) when PC_STACK_WRAP_EN is defined.
module pc_stack_unit #(
  parameter int ADDR_W      = 24,
  parameter int OFF_W       = 12,
  parameter int STEP        = 1,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_ADDR  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inc,
  input  logic                             load,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             clr_err,
  input  logic [ADDR_W-1:0]                IN,
  input  logic [OFF_W-1:0]                 OFFSET,
  output logic [ADDR_W-1:0]                OUT,
  output logic [$clog2(STACK_DEPTH):0]     depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc, pc_n, pc_step, branch_tgt;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  sp, sp_n, sp_top;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              err_q, err_n, err_set, push;

  assign pc_step    = pc + ADDR_W'(STEP);
  // OFF_W must be smaller than ADDR_W for the sign extension below
  assign branch_tgt = pc + {{(ADDR_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
  assign sp_top     = sp - PTR_W'(1);

  assign stack_full  = (cnt == CNT_W'(STACK_DEPTH));
  assign stack_empty = (cnt == '0);
  assign OUT   = pc;
  assign depth = cnt;
  assign err   = err_q;

  always_comb begin
    pc_n    = pc;
    sp_n    = sp;
    cnt_n   = cnt;
    push    = 1'b0;
    err_set = 1'b0;
    if (ret) begin
      if (stack_empty) begin
        err_set = 1'b1;
      end else begin
        pc_n  = stack_mem[sp_top];
        sp_n  = sp_top;
        cnt_n = cnt - CNT_W'(1);
      end
    end else if (call) begin
      if (!stack_full) begin
        push  = 1'b1;
        pc_n  = IN;
        sp_n  = sp + PTR_W'(1);
        cnt_n = cnt + CNT_W'(1);
      end else begin
`ifdef PC_STACK_WRAP_EN
        // sp already points at the oldest slot when full, so the push overwrites it
        push = 1'b1;
        pc_n = IN;
        sp_n = sp + PTR_W'(1);
`else
        err_set = 1'b1;
`endif
      end
    end else if (load) begin
      pc_n = IN;
    end else if (branch) begin
      pc_n = branch_tgt;
    end else if (inc) begin
      pc_n = pc_step;
    end
    if (err_set)      err_n = 1'b1;
    else if (clr_err) err_n = 1'b0;
    else              err_n = err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= ADDR_W'(RESET_ADDR);
      sp    <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      pc    <= pc_n;
      sp    <= sp_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) stack_mem[sp] <= pc_step;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc, load, branch, call, ret, clr_err;
  logic [23:0] in_addr;
  logic [11:0] offset;
  logic [23:0] pc_out;
  logic [3:0]  depth;
  logic        full, empty, err;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_stack[$];
  logic [23:0] exp_pc;

  always #5 clk = ~clk;

  pc_stack_unit dut (
    .clk(clk), .reset(rst_n), .inc(inc), .load(load), .branch(branch),
    .call(call), .ret(ret), .clr_err(clr_err), .IN(in_addr), .OFFSET(offset),
    .OUT(pc_out), .depth(depth), .stack_full(full), .stack_empty(empty), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic i, input logic l, input logic b, input logic c,
                     input logic r, input logic ce, input logic [23:0] a, input logic [11:0] o);
    inc = i; load = l; branch = b; call = c; ret = r; clr_err = ce;
    in_addr = a; offset = o;
    @(posedge clk); #1;
    inc = 0; load = 0; branch = 0; call = 0; ret = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    inc = 0; load = 0; branch = 0; call = 0; ret = 0; clr_err = 0;
    in_addr = '0; offset = '0; rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out", pc_out, 0);
    check("rst_depth", depth, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 3; k++) begin
      cmd(1, 0, 0, 0, 0, 0, 0, 0);
      check("inc_out", pc_out, k);
    end
    check("inc_depth", depth, 0);
    rst_n = 1'b0;
    cmd(1, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_out", pc_out, 0);
    rst_n = 1'b1;

    cmd(0, 1, 0, 0, 0, 0, 24'h000010, 0);
    check("load_out", pc_out, 24'h000010);
    cmd(0, 0, 1, 0, 0, 0, 0, 12'hFFC);
    check("br_neg", pc_out, 24'h00000C);
    cmd(0, 0, 1, 0, 0, 0, 0, 12'h005);
    check("br_pos", pc_out, 24'h000011);
    cmd(1, 0, 1, 0, 0, 0, 0, 12'h010);
    check("br_over_inc", pc_out, 24'h000021);
    cmd(0, 1, 0, 0, 0, 0, 24'hFFFFFF, 0);
    cmd(1, 0, 0, 0, 0, 0, 0, 0);
    check("inc_wrap", pc_out, 0);

    cmd(0, 1, 0, 0, 0, 0, 24'h000100, 0);
    cmd(0, 0, 0, 1, 0, 0, 24'h000200, 0);
    check("call1_out", pc_out, 24'h200);
    check("call1_depth", depth, 1);
    cmd(0, 0, 0, 1, 0, 0, 24'h000300, 0);
    check("call2_out", pc_out, 24'h300);
    check("call2_depth", depth, 2);
    cmd(0, 0, 0, 1, 1, 0, 24'h000700, 0);
    check("ret1_out", pc_out, 24'h201);
    check("ret1_depth", depth, 1);
    cmd(0, 0, 0, 0, 1, 0, 0, 0);
    check("ret2_out", pc_out, 24'h101);
    check("ret2_depth", depth, 0);

    cmd(0, 1, 0, 0, 0, 0, 24'h000010, 0);
    cmd(1, 1, 0, 1, 0, 0, 24'h000050, 0);
    check("prio_out", pc_out, 24'h050);
    check("prio_depth", depth, 1);
    cmd(0, 0, 0, 0, 1, 0, 0, 0);
    check("prio_top", pc_out, 24'h011);

    cmd(0, 0, 0, 0, 1, 0, 0, 0);
    check("uflow_out", pc_out, 24'h011);
    check("uflow_err", err, 1);
    check("uflow_depth", depth, 0);
    cmd(0, 0, 0, 0, 0, 1, 0, 0);
    check("clr_err", err, 0);

    do_reset();
    cmd(0, 0, 0, 0, 1, 0, 0, 0);
    check("rstret_out", pc_out, 0);
    check("rstret_err", err, 1);
    cmd(0, 0, 0, 0, 1, 1, 0, 0);
    check("setwins_err", err, 1);
    cmd(0, 0, 0, 0, 0, 1, 0, 0);
    check("clr2_err", err, 0);

    cmd(0, 0, 0, 1, 0, 0, 24'h000040, 0);
    rst_n = 1'b0;
    cmd(0, 0, 0, 1, 0, 0, 24'h000080, 0);
    check("rstcall_out", pc_out, 0);
    check("rstcall_depth", depth, 0);
    rst_n = 1'b1;

    exp_pc = 0;
    exp_stack.delete();
    for (int k = 0; k < 8; k++) begin
      exp_stack.push_back(exp_pc + 24'd1);
      exp_pc = 24'h001000 + 24'(k * 16);
      cmd(0, 0, 0, 1, 0, 0, exp_pc, 0);
    end
    check("fill_out", pc_out, exp_pc);
    check("fill_depth", depth, 8);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    cmd(0, 0, 0, 1, 0, 0, 24'h002000, 0);
`ifdef PC_STACK_WRAP_EN
    void'(exp_stack.pop_front());
    exp_stack.push_back(exp_pc + 24'd1);
    exp_pc = 24'h002000;
    check("wrap_out", pc_out, exp_pc);
    check("wrap_err", err, 0);
    check("wrap_depth", depth, 8);
`else
    check("oflow_out", pc_out, exp_pc);
    check("oflow_depth", depth, 8);
    check("oflow_err", err, 1);
    cmd(0, 0, 0, 0, 0, 1, 0, 0);
    check("oflow_clr", err, 0);
`endif
    for (int k = 0; k < 8; k++) begin
      exp_pc = exp_stack.pop_back();
      cmd(0, 0, 0, 0, 1, 0, 0, 0);
      check("lifo_out", pc_out, exp_pc);
      check("lifo_depth", depth, 7 - k);
    end
    check("drain_empty", empty, 1);
    check("drain_err", err, 0);
    cmd(0, 0, 0, 0, 1, 0, 0, 0);
    check("ret9_out", pc_out, exp_pc);
    check("ret9_err", err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program-counter block, next generation of the processor's PC register. Adds configurable address width and step, PC-relative branch, and a hardware call/return stack of configurable depth with full/empty status and a sticky error flag. Sits in the fetch stage. Driven by the control unit; feeds the instruction-memory address bus.

Parameters:
ADDR_W, 24, PC / address width in bits
OFF_W, 12, width of signed branch offset (two's complement)
STEP, 1, increment applied by inc and link address pushed by call
STACK_DEPTH, 8, return-address stack entries (power of two, >=2)
RESET_ADDR, 0, PC value loaded by reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
inc  input  1  PC <= PC + STEP
load  input  1  PC <= IN (absolute jump)
branch  input  1  PC <= PC + sext(OFFSET)
call  input  1  push PC + STEP, PC <= IN
ret  input  1  pop, PC <= popped address
clr_err  input  1  clears err
IN  input  ADDR_W  absolute target for load/call
OFFSET  input  OFF_W  signed relative branch offset
OUT  output  ADDR_W  current PC (registered)
depth  output  $clog2(STACK_DEPTH)+1  entries currently on stack
stack_full  output  1  depth == STACK_DEPTH
stack_empty  output  1  depth == 0
err  output  1  sticky: overflow or underflow occurred

Behaviour:
- All state registered; command sampled at edge N, result visible on OUT/depth after edge N (1-cycle latency). No combinational path from inputs to OUT.
- Reset (reset==0 at edge): OUT=RESET_ADDR, depth=0, err=0, stack_empty=1, stack_full=0; stack storage contents don't-care. Reset overrides every command, including mid-sequence call/ret.
- Command priority when several asserted (highest first): ret, call, load, branch, inc; none -> hold. Only the winner executes; losers ignored, no side effects.
- inc: OUT <= OUT + STEP mod 2^ADDR_W (wraps from all-ones to 0+STEP-1).
- load: OUT <= IN.
- branch: OUT <= OUT + sign-extend(OFFSET) to ADDR_W, mod 2^ADDR_W; base is the current OUT, not OUT+STEP.
- call, not full: stack[depth] <= OUT + STEP (mod 2^ADDR_W); depth+1; OUT <= IN.
- call, full (default build): no push, OUT holds, depth holds, err <= 1.
- ret, not empty: OUT <= stack[depth-1]; depth-1.
- ret, empty: OUT holds, depth holds, err <= 1.
- err: set on overflow/underflow; cleared by clr_err at next edge; set wins over clr_err in the same cycle.
- stack_full/stack_empty decoded from registered depth only.
- Stack is LIFO: nested calls return in reverse order.

Optional Feature:
PC_STACK_WRAP_EN
- Defined: stack is circular. call when full overwrites the oldest entry, executes the jump (OUT <= IN), depth stays STACK_DEPTH, err not set. ret on empty still sets err and holds.
- Not defined: overflow behaviour as in Behaviour (hold, err=1).

Test Plan:
- Reset then 3 cycles inc (ADDR_W=24, STEP=1) -> OUT 0,1,2,3; depth=0; stack_empty=1; reset held low mid-run -> OUT=0 next edge.
- OUT=0x000010, branch OFFSET=0xFFC (-4) -> OUT=0x00000C; then OFFSET=0x005 -> OUT=0x000011; OUT=0xFFFFFF, inc -> 0x000000.
- OUT=0x100, call IN=0x200; then call IN=0x300; ret; ret -> OUT 0x200, 0x300, 0x201, 0x101; depth 1,2,1,0.
- Same cycle inc=load=call=1, IN=0x050, OUT=0x010 -> OUT=0x050, depth+1, top=0x011 (call wins over load and inc).
- 8 calls (depth=8, full=1), 9th call -> OUT and depth unchanged, err=1; clr_err -> err=0; with PC_STACK_WRAP_EN 9th call -> OUT=IN, err=0, 8 rets return the newest 8 addresses, 9th ret -> err=1.
- ret on empty after reset -> OUT=RESET_ADDR unchanged, err=1; clr_err and ret together on empty -> err stays 1.
